// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide sequencer: 32-step shift-add multiply or
// restoring divide on magnitudes, followed by a one-cycle sign fix-up.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [2*WIDTH-1:0]   r_p, w_p_next;
  logic [WIDTH-1:0]     r_opnd, w_opnd_next;
  logic                 r_is_div, w_is_div_next;
  logic                 r_neg_q, w_neg_q_next;
  logic                 r_neg_r, w_neg_r_next;
  logic                 r_done, w_done_next;
  logic                 r_div_zero, w_div_zero_next;
  logic [WIDTH-1:0]     r_hi, w_hi_next;
  logic [WIDTH-1:0]     r_lo, w_lo_next;

  logic                 w_signed, w_sign_a, w_sign_b, w_b_zero;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic                 w_diff_ok;
  logic [2*WIDTH-1:0]   w_prod_neg;
  logic [WIDTH-1:0]     w_q_neg, w_r_neg;

  assign w_signed = ~op[0];
  assign w_sign_a = w_signed & dataA[WIDTH-1];
  assign w_sign_b = w_signed & dataB[WIDTH-1];
  assign w_b_zero = (dataB == {WIDTH{1'b0}});
  assign w_abs_a  = w_sign_a ? -dataA : dataA;
  assign w_abs_b  = w_sign_b ? -dataB : dataB;

  // Multiply step: conditional add of |A| into the upper half, keeping the carry.
  assign w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} +
                     (r_p[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // Divide step: the shifted remainder can reach 33 bits; if its top bit is set
  // it certainly exceeds the divisor, otherwise the borrow bit decides.
  assign w_rem_sh  = r_p[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_diff_ok = w_rem_sh[WIDTH] | ~w_diff[WIDTH];

  assign w_prod_neg = -r_p;
  assign w_q_neg    = -r_p[WIDTH-1:0];
  assign w_r_neg    = -r_p[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_p_next        = r_p;
    w_opnd_next     = r_opnd;
    w_is_div_next   = r_is_div;
    w_neg_q_next    = r_neg_q;
    w_neg_r_next    = r_neg_r;
    w_done_next     = 1'b0;
    w_div_zero_next = r_div_zero;
    w_hi_next       = r_hi;
    w_lo_next       = r_lo;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_div_zero_next = 1'b0;
          w_cnt_next      = {CNT_W{1'b0}};
          w_is_div_next   = op[1];
          w_neg_q_next    = w_sign_a ^ w_sign_b;
          w_neg_r_next    = w_sign_a;
          w_state_next    = RUN;
          if (op[1]) begin
            w_opnd_next = w_abs_b;
            w_p_next    = {{WIDTH{1'b0}}, w_abs_a};
            // Divide by zero: preload {R,Q} with the final result and let the
            // normal divide fix-up path pass it through unsigned.
            if (w_b_zero) begin
              w_p_next        = {dataA, {WIDTH{1'b1}}};
              w_neg_q_next    = 1'b0;
              w_neg_r_next    = 1'b0;
              w_div_zero_next = 1'b1;
              w_state_next    = FIX;
            end
          end else begin
            w_opnd_next = w_abs_a;
            w_p_next    = {{WIDTH{1'b0}}, w_abs_b};
          end
        end
      end
      RUN: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (r_is_div) begin
          if (w_diff_ok)
            w_p_next = {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
          else
            w_p_next = {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
        end else begin
          w_p_next = {w_mul_sum, r_p[WIDTH-1:1]};
        end
        if (r_cnt == CNT_W'(WIDTH-1))
          w_state_next = FIX;
      end
      FIX: begin
        w_done_next  = 1'b1;
        w_state_next = IDLE;
        if (r_is_div) begin
          w_lo_next = r_neg_q ? w_q_neg : r_p[WIDTH-1:0];
          w_hi_next = r_neg_r ? w_r_neg : r_p[2*WIDTH-1:WIDTH];
        end else begin
          {w_hi_next, w_lo_next} = r_neg_q ? w_prod_neg : r_p;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_p        <= {(2*WIDTH){1'b0}};
      r_opnd     <= {WIDTH{1'b0}};
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_p        <= w_p_next;
      r_opnd     <= w_opnd_next;
      r_is_div   <= w_is_div_next;
      r_neg_q    <= w_neg_q_next;
      r_neg_r    <= w_neg_r_next;
      r_done     <= w_done_next;
      r_div_zero <= w_div_zero_next;
      r_hi       <= w_hi_next;
      r_lo       <= w_lo_next;
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  muldiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural operation.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] rhi,
                                    output logic [31:0] rlo, output logic dz);
    logic [63:0] p;
    int sa, sb, q, r;
    dz = 1'b0;
    sa = int'(a);
    sb = int'(b);
    case (o)
      2'd0: p = 64'(longint'(sa) * longint'(sb));
      2'd1: p = {32'h0, a} * {32'h0, b};
      2'd2: begin
        if (b == 0) begin
          dz = 1'b1; p = {a, 32'hFFFFFFFF};
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          p = {32'h0, 32'h80000000};
        end else begin
          q = sa / sb; r = sa % sb; p = {r, q};
        end
      end
      default: begin
        if (b == 0) begin
          dz = 1'b1; p = {a, 32'hFFFFFFFF};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    rhi = p[63:32];
    rlo = p[31:0];
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after the accepting edge; returns at the negedge where done=1.
  task automatic wait_done(input string nm, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edz, input int ebusy, input int poke);
    int cyc = 0;
    bit seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk({nm, " busy_after_start"}, {31'b0, busy}, 32'd1);
        chk({nm, " done_low_while_busy"}, {31'b0, done}, 32'd0);
        chk({nm, " dz_at_start"}, {31'b0, div_zero}, {31'b0, edz});
        chk({nm, " hi_lo_hold"}, hi ^ lo, prev_hi ^ prev_lo);
      end
      if (start) start = 1'b0;
      if (k == poke) begin
        op = 2'b11; dataA = 32'd100; dataB = 32'd7; start = 1'b1;
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) cyc++;
    end
    if (!seen) chk({nm, " done_timeout"}, 32'd0, 32'd1);
    chk({nm, " hi"}, hi, ehi);
    chk({nm, " lo"}, lo, elo);
    chk({nm, " div_zero"}, {31'b0, div_zero}, {31'b0, edz});
    chk({nm, " busy_cycles"}, cyc, ebusy);
    $display("%s: hi=%h lo=%h dz=%0d busy_cycles=%0d", nm, hi, lo, div_zero, cyc);
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  initial begin
    logic [31:0] rhi, rlo, ra, rb;
    logic        rdz;
    logic [1:0]  rop;

    vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'd1, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
    vecs[8]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[10] = '{2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset div_zero", {31'b0, div_zero}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d op=%0d a=%h b=%h", i, vecs[i].op, vecs[i].a, vecs[i].b),
                vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz,
                vecs[i].exp_dz ? 1 : 33, -1);
      if (vecs[i].exp_dz) begin
        repeat (3) @(negedge clk);
        chk($sformatf("vec%0d dz_sticky", i), {31'b0, div_zero}, 32'd1);
      end
    end

    // Start during RUN ignored; start in the done cycle accepted immediately.
    start_op(2'd1, 32'd5, 32'd6);
    wait_done("seq5 MULTU 5*6 with mid-run start", 32'd0, 32'd30, 1'b0, 33, 10);
    start = 1'b1; op = 2'd1; dataA = 32'd9; dataB = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("seq5 back-to-back MULTU 9*9", 32'd0, 32'd81, 1'b0, 33, -1);

    // Asynchronous reset mid-operation.
    start_op(2'd1, 32'd5, 32'd6);
    repeat (12) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset busy", {31'b0, busy}, 32'd0);
    chk("async_reset done", {31'b0, done}, 32'd0);
    chk("async_reset hi", hi, 32'd0);
    chk("async_reset lo", lo, 32'd0);
    $display("async reset mid-op: busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
    @(negedge clk);
    reset = 1'b0;
    prev_hi = '0;
    prev_lo = '0;
    start_op(2'd1, 32'd9, 32'd9);
    wait_done("seq6 MULTU 9*9 after reset", 32'd0, 32'd81, 1'b0, 33, -1);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        2: ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ref_model(rop, ra, rb, rhi, rlo, rdz);
      start_op(rop, ra, rb);
      wait_done($sformatf("rand%0d op=%0d a=%h b=%h", i, rop, ra, rb),
                rhi, rlo, rdz, rdz ? 1 : 33, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
